watchdog_timer_mc: RTL
======================

// Module: watchdog_timer_mc
// PURPOSE
//  Multi-channel watchdog timer for the core bench and SoC top. Successor to the single
//  free-running overflow counter: adds a programmable timeout, an early-warning threshold,
//  a windowed-kick check, and sticky or auto-restart expiry on NUM_CH channels.
//  It sits beside CoreTop. Bench or firmware kicks each channel, and expiry stops the simulation.
// PARAMETERS
//  WIDTH      16  counter / threshold width in bits
//  NUM_CH     2   number of independent channels (1..8)
//  RST_TMO    24  timeout value loaded at reset (must be nonzero, < 2**WIDTH)
// PORTS
//  clk          in   1             clock
//  rst          in   1             synchronous reset, active-high
//  cfg_load     in   1             pulse: latch cfg_* into shared config registers
//  cfg_timeout  in   WIDTH         expiry threshold T
//  cfg_warn     in   WIDTH         warning threshold W (W >= T disables warning)
//  cfg_window   in   WIDTH         minimum legal kick count K (0 disables window check)
//  cfg_autorst  in   1             1 = expiry is a 1-cycle event, then auto-restart; 0 = sticky
//  cfg_err      out  1             pulse: cfg_load rejected
//  enable       in   NUM_CH        per-channel run enable (level)
//  kick         in   NUM_CH        per-channel service pulse
//  clear        in   NUM_CH        per-channel clear of sticky expiry
//  warn         out  NUM_CH        channel in WARN state
//  expired      out  NUM_CH        channel in EXPIRED state
//  early_fault  out  NUM_CH        sticky: last expiry was caused by an early kick
//  any_expired  out  1             OR of expired
//  count        out  NUM_CH*WIDTH  per-channel counters, ch0 in LSBs
// BEHAVIOUR
//  Reset: T=RST_TMO, W=all-ones, K=0, autorst=0; all channels IDLE, count=0, all outputs 0.
//  Config: cfg_load is accepted only when every channel is IDLE and cfg_timeout!=0. Values
//   take effect next cycle. Otherwise config is unchanged and cfg_err=1 for one cycle.
//  Per-channel FSM IDLE/RUN/WARN/EXPIRED. Each rule below is evaluated per cycle, top wins:
//   1. enable=0: next IDLE, count<=0, early_fault held. This holds in every state.
//   2. IDLE & enable: next RUN, count<=0.
//   3. RUN/WARN & kick & K!=0 & count<K: next EXPIRED, early_fault<=1, count holds.
//   4. RUN/WARN & kick (legal): next RUN, count<=0. A kick in the same cycle as count==T
//      wins, so no expiry occurs.
//   5. RUN/WARN & count==T: next EXPIRED, early_fault<=0, count holds at T.
//   6. RUN & count==W & W<T: next WARN, count+1.
//   7. RUN/WARN otherwise: count+1, saturating at all-ones. Counting never wraps.
//   8. EXPIRED & autorst: next RUN, count<=0. expired is high for exactly one cycle.
//   9. EXPIRED & !autorst: stay until clear=1, then next RUN, count<=0. kick is ignored.
//  Latency: with no kick, expired rises T+1 cycles after the first RUN cycle
//   (count 0..T, then EXPIRED). warn rises W+1 cycles after the first RUN cycle.
//  Outputs are registered: warn=(state==WARN), expired=(state==EXPIRED). No combinational
//   path runs from inputs to outputs.
//  Channels are fully independent. Only the config registers are shared.
//  rst asserted mid-count returns every channel and the config to reset values next cycle.
// TESTING
//  1 Reset defaults: enable[0]=1, no kicks -> count0 climbs 0..24, expired[0] high cycle 26,
//    stays high until clear[0]=1, then count0 restarts at 0.
//  2 Warn: T=10,W=6 -> warn[0] high from count 7 through 10; kick at count 8 -> warn drops
//    next cycle, count=0.
//  3 Window: T=20,K=5; kick at count 3 -> expired[0]=1, early_fault[0]=1; kick at count 5
//    -> legal, count=0.
//  4 Autorst: T=4,autorst=1 -> expired[0] pulses 1 cycle every 6 cycles; kick coinciding
//    with count==4 -> no pulse.
//  5 Config guard: cfg_load while ch1 RUN -> cfg_err=1, T unchanged; cfg_timeout=0 while all
//    IDLE -> cfg_err=1.
//  6 Independence/reset: ch0 EXPIRED, ch1 counting; drop enable[0] -> ch0 IDLE, ch1
//    unaffected; assert rst mid-run -> all counts 0, T=24 next cycle.

Source files
------------

// File: rtl/watchdog_timer_mc.sv
// Multi-channel watchdog: programmable timeout, early-warning threshold, windowed kick
// check and sticky or auto-restart expiry, with one shared configuration for all channels.
module watchdog_timer_mc #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned RST_TMO = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_load,
    input  logic [WIDTH-1:0]        cfg_timeout,
    input  logic [WIDTH-1:0]        cfg_warn,
    input  logic [WIDTH-1:0]        cfg_window,
    input  logic                    cfg_autorst,
    output logic                    cfg_err,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       kick,
    input  logic [NUM_CH-1:0]       clear,
    output logic [NUM_CH-1:0]       warn,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH-1:0]       early_fault,
    output logic                    any_expired,
    output logic [NUM_CH*WIDTH-1:0] count
);

    localparam int unsigned CW = WIDTH;
    localparam int unsigned NC = NUM_CH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WARN    = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    logic [CW-1:0] tmo_q;
    logic [CW-1:0] warn_thr_q;
    logic [CW-1:0] window_q;
    logic          autorst_q;

    logic [NC-1:0]    idle_c;
    logic [NC-1:0]    warn_d_c;
    logic [NC-1:0]    exp_d_c;
    logic [NC-1:0]    early_d_c;
    logic [NC*CW-1:0] count_d_c;
    logic             cfg_ok_c;

    // A config change is only safe when no channel is using the current thresholds.
    assign cfg_ok_c = cfg_load && (&idle_c) && (cfg_timeout != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q      <= CW'(RST_TMO);
            warn_thr_q <= '1;
            window_q   <= '0;
            autorst_q  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_ok_c;
            if (cfg_ok_c) begin
                tmo_q      <= cfg_timeout;
                warn_thr_q <= cfg_warn;
                window_q   <= cfg_window;
                autorst_q  <= cfg_autorst;
            end
        end
    end

    for (genvar ch = 0; ch < NC; ch++) begin : g_ch
        state_t        state_q;
        state_t        state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          early_d;

        assign cnt_q = count[ch*CW +: CW];

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Priority-ordered next-state rules; enable=0 overrides everything.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            early_d = early_fault[ch];
            if (!enable[ch]) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                    ST_RUN, ST_WARN: begin
                        if (kick[ch] && (window_q != '0) && (cnt_q < window_q)) begin
                            state_d = ST_EXPIRED;
                            early_d = 1'b1;
                        end else if (kick[ch]) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else if (cnt_q == tmo_q) begin
                            state_d = ST_EXPIRED;
                            early_d = 1'b0;
                        end else begin
                            if ((state_q == ST_RUN) && (cnt_q == warn_thr_q) &&
                                (warn_thr_q < tmo_q)) begin
                                state_d = ST_WARN;
                            end
                            if (cnt_q != '1) begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                    end
                    ST_EXPIRED: begin
                        if (autorst_q || clear[ch]) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign idle_c[ch]              = (state_q == ST_IDLE);
        assign warn_d_c[ch]            = (state_d == ST_WARN);
        assign exp_d_c[ch]             = (state_d == ST_EXPIRED);
        assign early_d_c[ch]           = early_d;
        assign count_d_c[ch*CW +: CW]  = cnt_d;
    end

    // Status outputs are flopped from next-state so they track the state registers exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            warn        <= '0;
            expired     <= '0;
            early_fault <= '0;
            any_expired <= 1'b0;
            count       <= '0;
        end else begin
            warn        <= warn_d_c;
            expired     <= exp_d_c;
            early_fault <= early_d_c;
            any_expired <= |exp_d_c;
            count       <= count_d_c;
        end
    end

endmodule
